// File: rtl/bullet_scheduler.sv
// Per-frame fire arbiter for a shared pool of bullet slots: edge-detects fire keys,
// applies cooldown and per-player caps, round-robins ties and allocates the lowest free slot.
module bullet_scheduler #(
    parameter int          NUM_SLOTS      = 4,
    parameter int          MAX_PER_PLAYER = 2,
    parameter int          COOLDOWN       = 8,
    parameter logic [7:0]  P1_FIRE_KEY    = 8'd44,
    parameter logic [7:0]  P2_FIRE_KEY    = 8'd40,
    localparam int         SW             = $clog2(NUM_SLOTS)
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [7:0]           keycode_a,
    input  logic [7:0]           keycode_b,
    input  logic [1:0]           p1_dir,
    input  logic [1:0]           p2_dir,
    input  logic [9:0]           p1_x,
    input  logic [9:0]           p1_y,
    input  logic [9:0]           p2_x,
    input  logic [9:0]           p2_y,
    input  logic [NUM_SLOTS-1:0] slot_done,
    output logic                 launch,
    output logic [SW-1:0]        launch_slot,
    output logic                 launch_owner,
    output logic [1:0]           launch_dir,
    output logic [9:0]           launch_x,
    output logic [9:0]           launch_y,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic [NUM_SLOTS-1:0] slot_owner,
    output logic [3:0]           p1_count,
    output logic [3:0]           p2_count
);

    localparam logic [3:0] MAX_CNT   = 4'(MAX_PER_PLAYER);
    localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN);

    function automatic logic [SW-1:0] lowest_free(input logic [NUM_SLOTS-1:0] busy);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy[i]) idx = SW'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] retire_count(input logic [NUM_SLOTS-1:0] ret,
                                                input logic [NUM_SLOTS-1:0] owner,
                                                input logic                 who);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (ret[i] && (owner[i] == who)) cnt = cnt + 4'd1;
        end
        return cnt;
    endfunction

    logic                 held1_r, held2_r;
    logic                 pend1_r, pend2_r;
    logic                 last_winner_r;
    logic [7:0]           cool1_r, cool2_r;

    logic                 down1_s, down2_s, press1_s, press2_s;
    logic                 elig1_s, elig2_s, req1_s, req2_s;
    logic                 grant1_s, grant2_s, grant_any_s;
    logic [SW-1:0]        free_slot_s;
    logic [NUM_SLOTS-1:0] retired_s, grant_onehot_s;
    logic [NUM_SLOTS-1:0] busy_next_s, owner_next_s;
    logic [3:0]           ret1_s, ret2_s, count1_next_s, count2_next_s;
    logic [7:0]           cool1_next_s, cool2_next_s;
    logic [1:0]           win_dir_s;
    logic [9:0]           win_x_s, win_y_s;

    // Key edge detection, eligibility and round-robin grant from pre-edge state
    always_comb begin
        down1_s     = (keycode_a == P1_FIRE_KEY) || (keycode_b == P1_FIRE_KEY);
        down2_s     = (keycode_a == P2_FIRE_KEY) || (keycode_b == P2_FIRE_KEY);
        press1_s    = down1_s & ~held1_r;
        press2_s    = down2_s & ~held2_r;
        elig1_s     = (cool1_r == 8'd0) && (p1_count < MAX_CNT) && !(&slot_busy);
        elig2_s     = (cool2_r == 8'd0) && (p2_count < MAX_CNT) && !(&slot_busy);
        req1_s      = (press1_s | pend1_r) & elig1_s;
        req2_s      = (press2_s | pend2_r) & elig2_s;
        // last_winner_r = 1 means P2 won last, so P1 takes a tie
        grant1_s    = req1_s & (~req2_s | last_winner_r);
        grant2_s    = req2_s & (~req1_s | ~last_winner_r);
        grant_any_s = grant1_s | grant2_s;
        free_slot_s = lowest_free(slot_busy);
    end

    // Slot occupancy, owner counts, cooldowns and winner launch payload
    always_comb begin
        retired_s      = slot_done & slot_busy;
        grant_onehot_s = {NUM_SLOTS{grant_any_s}} & (NUM_SLOTS'(1) << free_slot_s);
        busy_next_s    = (slot_busy & ~retired_s) | grant_onehot_s;
        owner_next_s   = (slot_owner & ~grant_onehot_s) | ({NUM_SLOTS{grant2_s}} & grant_onehot_s);
        ret1_s         = retire_count(retired_s, slot_owner, 1'b0);
        ret2_s         = retire_count(retired_s, slot_owner, 1'b1);
        count1_next_s  = p1_count - ret1_s + {3'b000, grant1_s};
        count2_next_s  = p2_count - ret2_s + {3'b000, grant2_s};
        if (grant1_s) begin
            cool1_next_s = COOL_LOAD;
        end else if (cool1_r != 8'd0) begin
            cool1_next_s = cool1_r - 8'd1;
        end else begin
            cool1_next_s = 8'd0;
        end
        if (grant2_s) begin
            cool2_next_s = COOL_LOAD;
        end else if (cool2_r != 8'd0) begin
            cool2_next_s = cool2_r - 8'd1;
        end else begin
            cool2_next_s = 8'd0;
        end
        if (grant2_s) begin
            win_dir_s = p2_dir;
            win_x_s   = p2_x;
            win_y_s   = p2_y;
        end else begin
            win_dir_s = p1_dir;
            win_x_s   = p1_x;
            win_y_s   = p1_y;
        end
    end

    // State and registered outputs; held keys start as held so a key down through reset is ignored
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            held1_r       <= 1'b1;
            held2_r       <= 1'b1;
            pend1_r       <= 1'b0;
            pend2_r       <= 1'b0;
            last_winner_r <= 1'b1;
            cool1_r       <= 8'd0;
            cool2_r       <= 8'd0;
            launch        <= 1'b0;
            launch_slot   <= '0;
            launch_owner  <= 1'b0;
            launch_dir    <= 2'd0;
            launch_x      <= 10'd0;
            launch_y      <= 10'd0;
            slot_busy     <= '0;
            slot_owner    <= '0;
            p1_count      <= 4'd0;
            p2_count      <= 4'd0;
        end else begin
            held1_r    <= down1_s;
            held2_r    <= down2_s;
            pend1_r    <= req1_s & ~grant1_s;
            pend2_r    <= req2_s & ~grant2_s;
            cool1_r    <= cool1_next_s;
            cool2_r    <= cool2_next_s;
            slot_busy  <= busy_next_s;
            slot_owner <= owner_next_s;
            p1_count   <= count1_next_s;
            p2_count   <= count2_next_s;
            launch     <= grant_any_s;
            if (grant_any_s) begin
                last_winner_r <= grant2_s;
                launch_slot   <= free_slot_s;
                launch_owner  <= grant2_s;
                launch_dir    <= win_dir_s;
                launch_x      <= win_x_s;
                launch_y      <= win_y_s;
            end
        end
    end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Scoreboard bench for bullet_scheduler: scenario tasks queue expected launches,
// a negedge monitor pops and compares them against each launch strobe.
module tb_bullet_scheduler;

    localparam int NS = 4;
    localparam int SW = 2;

    logic          frame_clk;
    logic          Reset;
    logic [7:0]    keycode_a, keycode_b;
    logic [1:0]    p1_dir, p2_dir;
    logic [9:0]    p1_x, p1_y, p2_x, p2_y;
    logic [NS-1:0] slot_done;
    logic          launch;
    logic [SW-1:0] launch_slot;
    logic          launch_owner;
    logic [1:0]    launch_dir;
    logic [9:0]    launch_x, launch_y;
    logic [NS-1:0] slot_busy, slot_owner;
    logic [3:0]    p1_count, p2_count;

    typedef struct {
        int            edge_n;
        logic [SW-1:0] slot;
        logic          owner;
        logic [1:0]    dir;
        logic [9:0]    x;
        logic [9:0]    y;
    } launch_t;

    launch_t exp_q[$];
    launch_t mon_exp;
    int      vectors = 0;
    int      miscompares = 0;
    int      cyc = 0;

    bullet_scheduler dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .keycode_a(keycode_a), .keycode_b(keycode_b),
        .p1_dir(p1_dir), .p2_dir(p2_dir),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .slot_done(slot_done),
        .launch(launch), .launch_slot(launch_slot), .launch_owner(launch_owner),
        .launch_dir(launch_dir), .launch_x(launch_x), .launch_y(launch_y),
        .slot_busy(slot_busy), .slot_owner(slot_owner),
        .p1_count(p1_count), .p2_count(p2_count)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    always @(posedge frame_clk) cyc <= cyc + 1;

    // Every launch strobe must match the oldest queued expectation, including its edge number
    always @(negedge frame_clk) begin
        if (launch === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_launch: got launch at edge %0d slot %0d owner %0d, required none",
                         cyc, launch_slot, launch_owner);
            end else begin
                mon_exp = exp_q.pop_front();
                if (cyc !== mon_exp.edge_n || launch_slot !== mon_exp.slot || launch_owner !== mon_exp.owner ||
                    launch_dir !== mon_exp.dir || launch_x !== mon_exp.x || launch_y !== mon_exp.y) begin
                    miscompares++;
                    $display("FAIL launch_fields: got edge %0d slot %0d owner %0d dir %b x %0d y %0d, required edge %0d slot %0d owner %0d dir %b x %0d y %0d",
                             cyc, launch_slot, launch_owner, launch_dir, launch_x, launch_y,
                             mon_exp.edge_n, mon_exp.slot, mon_exp.owner, mon_exp.dir, mon_exp.x, mon_exp.y);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_frame(input logic [7:0] ka, input logic [7:0] kb, input logic [NS-1:0] done);
        @(negedge frame_clk);
        keycode_a = ka;
        keycode_b = kb;
        slot_done = done;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_frame(8'd0, 8'd0, 4'b0000);
    endtask

    task automatic expect_launch(input int edge_n, input logic owner, input logic [SW-1:0] slot);
        launch_t e;
        e.edge_n = edge_n;
        e.slot   = slot;
        e.owner  = owner;
        e.dir    = owner ? p2_dir : p1_dir;
        e.x      = owner ? p2_x : p1_x;
        e.y      = owner ? p2_y : p1_y;
        exp_q.push_back(e);
    endtask

    // One-frame key press then release; P1 uses keycode_a, P2 uses keycode_b
    task automatic tap(input logic who, input bit exp, input logic [SW-1:0] slot);
        drive_frame(who ? 8'd0 : 8'd44, who ? 8'd40 : 8'd0, 4'b0000);
        if (exp) expect_launch(cyc + 1, who, slot);
        drive_frame(8'd0, 8'd0, 4'b0000);
    endtask

    task automatic do_reset();
        @(negedge frame_clk);
        Reset = 1'b1; keycode_a = 8'd0; keycode_b = 8'd0; slot_done = 4'b0000;
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge frame_clk);
        vectors++;
        if ({launch, launch_slot, launch_owner, launch_dir} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_launch: got %b, required 000000", {launch, launch_slot, launch_owner, launch_dir});
        end
        vectors++;
        if ({launch_x, launch_y} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_pos: got x %0d y %0d, required 0 0", launch_x, launch_y);
        end
        vectors++;
        if ({slot_busy, slot_owner, p1_count, p2_count} !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy %b owner %b c1 %0d c2 %0d, required all 0",
                     slot_busy, slot_owner, p1_count, p2_count);
        end
        Reset = 1'b0;
    endtask

    task automatic test_single_fire();
        p1_dir = 2'b01; p1_x = 10'd100; p1_y = 10'd200;
        drive_frame(8'd44, 8'd0, 4'b0000);
        expect_launch(cyc + 1, 1'b0, 2'd0);
        drive_frame(8'd44, 8'd0, 4'b0000);
        drive_frame(8'd44, 8'd0, 4'b0000);
        idle(2);
        vectors++;
        if (p1_count !== 4'd1 || slot_busy !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_state: got c1 %0d busy %b, required 1 0001", p1_count, slot_busy);
        end
        drive_frame(8'd0, 8'd0, 4'b0001);
        idle(1);
        vectors++;
        if (p1_count !== 4'd0 || slot_busy !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_retire: got c1 %0d busy %b, required 0 0000", p1_count, slot_busy);
        end
        idle(3);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_missing: got %0d launches outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_tie();
        do_reset();
        p1_dir = 2'b00; p1_x = 10'd5;   p1_y = 10'd7;
        p2_dir = 2'b11; p2_x = 10'd300; p2_y = 10'd40;
        drive_frame(8'd44, 8'd40, 4'b0000);
        expect_launch(cyc + 1, 1'b0, 2'd0);
        expect_launch(cyc + 2, 1'b1, 2'd1);
        drive_frame(8'd44, 8'd40, 4'b0000);
        drive_frame(8'd0, 8'd0, 4'b0000);
        vectors++;
        if (slot_busy !== 4'b0011 || slot_owner[1:0] !== 2'b10 || p1_count !== 4'd1 || p2_count !== 4'd1) begin
            miscompares++;
            $display("FAIL tie_state: got busy %b owner %b c1 %0d c2 %0d, required 0011 xx10 1 1",
                     slot_busy, slot_owner, p1_count, p2_count);
        end
        drive_frame(8'd0, 8'd0, 4'b0011);
        idle(8);
        tap(1'b0, 1'b1, 2'd0);
        idle(10);
        p2_dir = 2'b10; p2_x = 10'd511; p2_y = 10'd1;
        drive_frame(8'd40, 8'd44, 4'b0000);
        expect_launch(cyc + 1, 1'b1, 2'd1);
        expect_launch(cyc + 2, 1'b0, 2'd2);
        drive_frame(8'd40, 8'd44, 4'b0000);
        idle(2);
        vectors++;
        if (slot_busy !== 4'b0111 || slot_owner[2:0] !== 3'b010 || p1_count !== 4'd2 || p2_count !== 4'd1) begin
            miscompares++;
            $display("FAIL tie2_state: got busy %b owner %b c1 %0d c2 %0d, required 0111 x010 2 1",
                     slot_busy, slot_owner, p1_count, p2_count);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL tie_missing: got %0d launches outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_caps();
        do_reset();
        p1_dir = 2'b10; p1_x = 10'd64; p1_y = 10'd128;
        tap(1'b0, 1'b1, 2'd0);
        idle(9);
        tap(1'b0, 1'b1, 2'd1);
        idle(9);
        tap(1'b0, 1'b0, 2'd0);
        idle(3);
        vectors++;
        if (p1_count !== 4'd2 || slot_busy !== 4'b0011) begin
            miscompares++;
            $display("FAIL caps_drop: got c1 %0d busy %b, required 2 0011", p1_count, slot_busy);
        end
        drive_frame(8'd0, 8'd0, 4'b0001);
        idle(3);
        tap(1'b0, 1'b1, 2'd0);
        idle(2);
        vectors++;
        if (p1_count !== 4'd2 || slot_busy !== 4'b0011) begin
            miscompares++;
            $display("FAIL caps_refill: got c1 %0d busy %b, required 2 0011", p1_count, slot_busy);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL caps_missing: got %0d launches outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_cooldown();
        do_reset();
        p1_dir = 2'b01; p1_x = 10'd1023; p1_y = 10'd0;
        tap(1'b0, 1'b1, 2'd0);
        idle(3);
        tap(1'b0, 1'b0, 2'd0);
        idle(2);
        tap(1'b0, 1'b1, 2'd1);
        idle(3);
        vectors++;
        if (p1_count !== 4'd2) begin
            miscompares++;
            $display("FAIL cooldown_count: got %0d, required 2", p1_count);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL cooldown_missing: got %0d launches outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_pool_full();
        do_reset();
        p1_dir = 2'b11; p1_x = 10'd20;  p1_y = 10'd30;
        p2_dir = 2'b00; p2_x = 10'd600; p2_y = 10'd400;
        tap(1'b0, 1'b1, 2'd0);
        tap(1'b1, 1'b1, 2'd1);
        idle(9);
        tap(1'b1, 1'b1, 2'd2);
        tap(1'b0, 1'b1, 2'd3);
        vectors++;
        if (slot_busy !== 4'b1111 || slot_owner !== 4'b0110 || p1_count !== 4'd2 || p2_count !== 4'd2) begin
            miscompares++;
            $display("FAIL pool_fill: got busy %b owner %b c1 %0d c2 %0d, required 1111 0110 2 2",
                     slot_busy, slot_owner, p1_count, p2_count);
        end
        idle(10);
        drive_frame(8'd0, 8'd40, 4'b0100);
        drive_frame(8'd0, 8'd0, 4'b0000);
        vectors++;
        if (slot_busy !== 4'b1011 || p2_count !== 4'd1) begin
            miscompares++;
            $display("FAIL pool_retire: got busy %b c2 %0d, required 1011 1", slot_busy, p2_count);
        end
        drive_frame(8'd0, 8'd40, 4'b0001);
        expect_launch(cyc + 1, 1'b1, 2'd2);
        drive_frame(8'd0, 8'd0, 4'b0000);
        vectors++;
        if (slot_busy !== 4'b1110 || slot_owner[2] !== 1'b1 || p1_count !== 4'd1 || p2_count !== 4'd2) begin
            miscompares++;
            $display("FAIL pool_same_edge: got busy %b owner %b c1 %0d c2 %0d, required 1110 x1xx 1 2",
                     slot_busy, slot_owner, p1_count, p2_count);
        end
        idle(3);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pool_missing: got %0d launches outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_held();
        do_reset();
        p1_dir = 2'b01; p1_x = 10'd77;  p1_y = 10'd88;
        p2_dir = 2'b10; p2_x = 10'd99;  p2_y = 10'd11;
        tap(1'b0, 1'b1, 2'd0);
        tap(1'b1, 1'b1, 2'd1);
        @(negedge frame_clk);
        Reset = 1'b1; keycode_a = 8'd44; keycode_b = 8'd0; slot_done = 4'b0000;
        @(negedge frame_clk);
        Reset = 1'b0;
        vectors++;
        if ({launch, launch_slot, launch_owner, launch_dir, launch_x, launch_y} !== 26'd0 ||
            {slot_busy, slot_owner, p1_count, p2_count} !== 16'd0) begin
            miscompares++;
            $display("FAIL held_reset_zero: got launch %b busy %b owner %b c1 %0d c2 %0d x %0d, required all 0",
                     launch, slot_busy, slot_owner, p1_count, p2_count, launch_x);
        end
        repeat (3) drive_frame(8'd44, 8'd0, 4'b0000);
        drive_frame(8'd0, 8'd0, 4'b0000);
        vectors++;
        if (slot_busy !== 4'b0000) begin
            miscompares++;
            $display("FAIL held_no_fire: got busy %b, required 0000", slot_busy);
        end
        tap(1'b0, 1'b1, 2'd0);
        idle(2);
        vectors++;
        if (p1_count !== 4'd1 || p2_count !== 4'd0 || slot_busy !== 4'b0001) begin
            miscompares++;
            $display("FAIL held_refire: got c1 %0d c2 %0d busy %b, required 1 0 0001", p1_count, p2_count, slot_busy);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL held_missing: got %0d launches outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        keycode_a = 8'd0; keycode_b = 8'd0; slot_done = 4'b0000;
        p1_dir = 2'b00; p2_dir = 2'b00;
        p1_x = 10'd0; p1_y = 10'd0; p2_x = 10'd0; p2_y = 10'd0;
        test_reset();
        test_single_fire();
        test_tie();
        test_caps();
        test_cooldown();
        test_pool_full();
        test_reset_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
